// File: rtl/cordic_arb_pkg.sv
// Shared types for the CORDIC rotation arbiter: FSM states, pipeline tag, data width.
package cordic_arb_pkg;

  localparam int unsigned DataW  = 16;
  // Tag id field is sized for up to 16 requesters.
  localparam int unsigned TagIdW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic [TagIdW-1:0] id;
  } tag_t;

endpackage

// File: rtl/cordic_rsp_fifo.sv
// Single-clock result FIFO holding packed {x, y} CORDIC results for one requester.
module cordic_rsp_fifo #(
  parameter int unsigned Depth  = 4,
  parameter int unsigned EntryW = 32,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [EntryW-1:0] wdata_i,
  input  logic              pop_i,
  output logic [EntryW-1:0] rdata_o,
  output logic [CntW-1:0]   count_o,
  output logic              empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [EntryW-1:0] mem_q [Depth];
  logic [AddrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              pop_ok;

  assign empty_o = (cnt_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  assign count_o = cnt_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_ok) rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cordic_rot_arbiter.sv
// Round-robin, credit-based arbiter sharing one rotational CORDIC pipeline among NREQ requesters.
// Optional tag/done consistency checking is enabled by defining CORDIC_ARB_CHECK_EN.
module cordic_rot_arbiter
  import cordic_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned LATENCY   = 15
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       en_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ-1:0][DataW-1:0] req_x_i,
  input  logic [NREQ-1:0][DataW-1:0] req_y_i,
  input  logic [NREQ-1:0][DataW-1:0] req_theta_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic [NREQ-1:0]            rsp_valid_o,
  input  logic [NREQ-1:0]            rsp_ready_i,
  output logic [NREQ-1:0][DataW-1:0] rsp_x_o,
  output logic [NREQ-1:0][DataW-1:0] rsp_y_o,
  output logic                       cordic_start_o,
  output logic [DataW-1:0]           cordic_x_o,
  output logic [DataW-1:0]           cordic_y_o,
  output logic [DataW-1:0]           cordic_theta_o,
  input  logic                       cordic_done_i,
  input  logic [DataW-1:0]           cordic_xprime_i,
  input  logic [DataW-1:0]           cordic_yprime_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CntW = $clog2(RES_DEPTH + 1);
  localparam int unsigned FlW  = $clog2(LATENCY + 1);
  localparam logic [CntW:0] DepthC = (CntW + 1)'(RES_DEPTH);

  arb_state_t       state_q, state_d;
  logic [PtrW-1:0]  rr_q, rr_d;
  tag_t             tag_q [LATENCY];
  tag_t             tag_out;
  logic [FlW-1:0]   fl_q, fl_d;
  logic [CntW-1:0]  req_fl_q [NREQ];
  logic [CntW-1:0]  req_fl_d [NREQ];
  logic [CntW-1:0]  fifo_cnt [NREQ];
  logic [2*DataW-1:0] fifo_rdata [NREQ];
  logic [NREQ-1:0]  fifo_empty, push, pop, credit_ok, eligible;
  logic             gnt_found;
  logic [PtrW-1:0]  gnt_id;

  assign tag_out = tag_q[LATENCY-1];
  assign busy_o  = (state_q != StIdle);

  // First eligible requester at or after the round-robin pointer; no grants while in reset.
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (int'(rr_q) + k) % int'(NREQ);
      if (!gnt_found && reset_ni && (state_q == StRun) && eligible[PtrW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_id    = PtrW'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o    = gnt_found ? (NREQ'(1) << gnt_id) : '0;
    cordic_start_o = gnt_found;
    cordic_x_o     = gnt_found ? req_x_i[gnt_id] : '0;
    cordic_y_o     = gnt_found ? req_y_i[gnt_id] : '0;
    cordic_theta_o = gnt_found ? req_theta_i[gnt_id] : '0;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_found) rr_d = (gnt_id == PtrW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    fl_d = fl_q + FlW'(cordic_start_o) - FlW'(tag_out.valid);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (en_i) state_d = StRun;
      StRun:   if (!en_i) state_d = (fl_q != '0) ? StDrain : StIdle;
      StDrain: begin
        if (en_i)              state_d = StRun;
        else if (fl_q == '0)   state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  for (genvar i = 0; i < int'(NREQ); i++) begin : g_req
    assign push[i]      = tag_out.valid && (tag_out.id == TagIdW'(i));
    assign pop[i]       = rsp_valid_o[i] && rsp_ready_i[i];
    // Credit counts FIFO slots plus results still in the pipeline, so a push can never overflow.
    assign credit_ok[i] = ({1'b0, fifo_cnt[i]} + {1'b0, req_fl_q[i]}) < DepthC;
    assign eligible[i]  = req_valid_i[i] && credit_ok[i];
    assign req_fl_d[i]  = req_fl_q[i] + CntW'(req_ready_o[i]) - CntW'(push[i]);
    assign rsp_valid_o[i] = !fifo_empty[i];
    assign rsp_x_o[i]   = fifo_rdata[i][2*DataW-1:DataW];
    assign rsp_y_o[i]   = fifo_rdata[i][DataW-1:0];

    cordic_rsp_fifo #(
      .Depth  (RES_DEPTH),
      .EntryW (2 * DataW)
    ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (reset_ni),
      .push_i  (push[i]),
      .wdata_i ({cordic_xprime_i, cordic_yprime_i}),
      .pop_i   (pop[i]),
      .rdata_o (fifo_rdata[i]),
      .count_o (fifo_cnt[i]),
      .empty_o (fifo_empty[i])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= StIdle;
      rr_q    <= '0;
      fl_q    <= '0;
      for (int k = 0; k < int'(LATENCY); k++) tag_q[k] <= '0;
      for (int i = 0; i < int'(NREQ); i++) req_fl_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      fl_q     <= fl_d;
      tag_q[0] <= '{valid: cordic_start_o, id: TagIdW'(gnt_id)};
      for (int k = 1; k < int'(LATENCY); k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < int'(NREQ); i++) req_fl_q[i] <= req_fl_d[i];
    end
  end

`ifdef CORDIC_ARB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      err_q <= 1'b0;
    end else if (cordic_done_i != tag_out.valid) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_done;
  assign unused_done = cordic_done_i;
  assign err_o       = 1'b0;
`endif

endmodule
